serial_syllable_assembler: RTL and testbench
============================================

# serial_syllable_assembler

Serial-to-parallel assembler for the write path of the transfer register. It captures the LSB-first serial bit stream shifted out of the transfer register into one 13-bit syllable and accumulates a running parity bit while doing so. It then offers the syllable, its parity and the syllable select to the memory write buffer over a valid/ready handshake. It is the receiving end of the serial shift that the transfer register performs during SRTR.

## Interface
Parameters:
- SYL_BITS, 13, data bits per syllable (excluding parity)
- PAR_ODD, 1, 1 = odd parity generated/checked, 0 = even

Ports:
- CLK  in  1  system clock; one clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  single-cycle pulse: begin a new syllable
- SYL_SEL  in  1  syllable select, sampled with an accepted START
- BIT_STB  in  1  bit-time strobe, one cycle per serial bit
- SHIFT_EN  in  1  shift active; a bit is sampled only when BIT_STB & SHIFT_EN
- SER_DATA  in  1  serial data bit, LSB first
- WR_READY  in  1  write buffer accepts the word
- WR_VALID  out  1  assembled syllable available
- WR_DATA  out  SYL_BITS  assembled syllable
- WR_PAR  out  1  generated parity over WR_DATA
- WR_SYL  out  1  SYL_SEL captured at START
- BUSY  out  1  high in SHIFT or WAIT_WR
- PAR_ERR  out  1  received parity mismatch (constant 0 without the macro)
- OVERRUN  out  1  sticky: a bit or START arrived while in WAIT_WR

## Operation
- States: IDLE, SHIFT, WAIT_WR.
- **IDLE**:
  - START → SHIFT; clear the bit counter, shift register and parity accumulator; latch SYL_SEL into WR_SYL; clear OVERRUN.
  - BIT_STB is ignored in IDLE, including in the same cycle as START.
- **SHIFT**:
  - Each sampled bit (BIT_STB & SHIFT_EN) is written to WR_DATA[count]. The counter increments and the parity accumulator XORs in the bit.
  - BIT_STB with SHIFT_EN low is a gap: no state change.
  - After the last bit → WAIT_WR. Without the macro the last bit is bit index SYL_BITS-1. With the macro it is the received parity bit at index SYL_BITS.
  - START in SHIFT aborts the syllable and restarts exactly as from IDLE; partial data is discarded.
- **WAIT_WR**:
  - WR_VALID = 1. WR_DATA, WR_PAR, WR_SYL and PAR_ERR are stable.
  - WR_VALID & WR_READY at a clock edge → IDLE, or → SHIFT if START is high in the same cycle (back-to-back).
  - A sampled bit in WAIT_WR is dropped and sets OVERRUN.
  - START in WAIT_WR without WR_READY is ignored and sets OVERRUN.
- **Parity**: WR_PAR = (^WR_DATA) ^ PAR_ODD, i.e. the total count of 1s including WR_PAR is odd when PAR_ODD = 1.
- **Counter**: width $clog2(SYL_BITS+2). It never wraps, because reaching the terminal count always forces WAIT_WR.

## Timing
- Reset values: state IDLE, WR_VALID 0, WR_DATA 0, WR_PAR = PAR_ODD (parity of zero data), WR_SYL 0, BUSY 0, PAR_ERR 0, OVERRUN 0, counter 0.
- RESET mid-operation (SHIFT or WAIT_WR) takes effect on the next edge and discards the word. No handshake completes in that cycle.
- BUSY rises on the edge that accepts START.
- WR_VALID rises on the edge that samples the last bit. Latency is 0 cycles after the final BIT_STB edge, so outputs are registered and visible in the following cycle.
- WR_VALID falls on the edge where WR_READY is sampled high.
- The minimum bit spacing is 1 cycle; BIT_STB may be high on consecutive cycles.

## Configuration
- Macro: SERIAL_ASSEMBLER_PARITY_CHECK_EN.
- **Defined**:
  - One extra serial bit, the transmitted parity, follows the data bits.
  - That bit is not stored in WR_DATA.
  - PAR_ERR = received bit != generated parity. It is set together with WR_VALID and cleared on handshake, START or RESET.
  - WR_PAR remains the generated value.
- **Undefined**:
  - The syllable ends after SYL_BITS bits.
  - PAR_ERR is tied to 0 and has no flop.

## Structure
- Package lvdc_xfer_pkg holds:
  - SYL_BITS default constant
  - the state enum (IDLE, SHIFT, WAIT_WR)
  - a parity function, shared with the future read-side checker
- One sub-module, parity_accum: a 1-bit running XOR flop with clear and enable inputs, the same function as the POD/PDD pair in the transfer logic. It is instantiated once.

## Test plan
- Reset, START with SYL_SEL = 1, then 13 bits of 0x1A5B LSB first on consecutive strobes → WR_VALID, WR_DATA = 0x1A5B, WR_SYL = 1, WR_PAR = 1 (8 ones, odd parity). With WR_READY = 1 → IDLE the next cycle.
- Bits spaced with SHIFT_EN-low gaps and BIT_STB pulses between them → the same WR_DATA as the contiguous case; the gap strobes have no effect.
- START after 6 bits → the counter restarts. The following 13 bits alone form WR_DATA, and WR_SYL is updated.
- Hold WR_READY = 0 and drive 2 extra strobes plus a START → WR_DATA is unchanged and OVERRUN = 1. A later START with WR_READY = 1 in the same cycle completes the handshake, enters SHIFT and clears OVERRUN.
- With the macro defined: data 0x0001 followed by parity bit 1 → PAR_ERR = 1 (expected 0). With parity bit 0 → PAR_ERR = 0.
- RESET asserted in WAIT_WR and in mid-SHIFT → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/serial_syllable_assembler_pkg.sv
// rtl/serial_syllable_assembler_pkg.sv - shared constants, state enum and parity helper for the transfer-register write path
package lvdc_xfer_pkg;

  localparam int LVDC_SYL_BITS = 13;
  localparam int LVDC_PAR_MAX  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_WR = 2'd2
  } xfer_state_t;

  // Narrower syllables are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic syl_parity(input logic [LVDC_PAR_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_syllable_assembler_if.sv
// rtl/serial_syllable_assembler_if.sv - serial input, write-buffer handshake and status bundle of the syllable assembler
interface serial_syllable_assembler_if #(
  parameter int SYL_BITS = lvdc_xfer_pkg::LVDC_SYL_BITS
);

  logic                START;
  logic                SYL_SEL;
  logic                BIT_STB;
  logic                SHIFT_EN;
  logic                SER_DATA;
  logic                WR_READY;
  logic                WR_VALID;
  logic [SYL_BITS-1:0] WR_DATA;
  logic                WR_PAR;
  logic                WR_SYL;
  logic                BUSY;
  logic                PAR_ERR;
  logic                OVERRUN;

  modport master (
    output START, SYL_SEL, BIT_STB, SHIFT_EN, SER_DATA, WR_READY,
    input  WR_VALID, WR_DATA, WR_PAR, WR_SYL, BUSY, PAR_ERR, OVERRUN
  );

  modport slave (
    input  START, SYL_SEL, BIT_STB, SHIFT_EN, SER_DATA, WR_READY,
    output WR_VALID, WR_DATA, WR_PAR, WR_SYL, BUSY, PAR_ERR, OVERRUN
  );

endinterface

// File: rtl/serial_syllable_assembler_parity_accum.sv
// rtl/serial_syllable_assembler_parity_accum.sv - 1-bit running XOR flop with clear and enable
module parity_accum (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/serial_syllable_assembler.sv
// rtl/serial_syllable_assembler.sv - LSB-first serial-to-syllable assembler with write handshake
// Optional received-parity check: SERIAL_ASSEMBLER_PARITY_CHECK_EN
module serial_syllable_assembler
  import lvdc_xfer_pkg::*;
#(
  parameter int SYL_BITS = LVDC_SYL_BITS,
  parameter bit PAR_ODD  = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  serial_syllable_assembler_if.slave  bus
);

  localparam int CW = $clog2(SYL_BITS + 2);
`ifdef SERIAL_ASSEMBLER_PARITY_CHECK_EN
  localparam int LAST_IDX = SYL_BITS;
`else
  localparam int LAST_IDX = SYL_BITS - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST_IDX);
  localparam logic [CW-1:0] DATA_CNT = CW'(SYL_BITS);

  xfer_state_t         state;
  logic [CW-1:0]       cnt;
  logic [SYL_BITS-1:0] data_q;
  logic                syl_q;
  logic                valid_q;
  logic                busy_q;
  logic                ovr_q;
  logic                acc_q;

  logic sample;
  logic handshake;
  logic start_accept;
  logic data_bit;
  logic last_bit;
  logic acc_clr;
  logic acc_en;
  logic wr_par;

  assign sample       = bus.BIT_STB & bus.SHIFT_EN;
  assign handshake    = (state == WAIT_WR) & bus.WR_READY;
  // START is honoured everywhere except a stalled WAIT_WR
  assign start_accept = bus.START & ((state != WAIT_WR) | bus.WR_READY);
  assign data_bit     = (state == SHIFT) & ~bus.START & sample;
  assign last_bit     = data_bit & (cnt == LAST_CNT);
  assign acc_clr      = RESET | start_accept;
  // The received parity bit, when present, is kept out of the accumulator
  assign acc_en       = data_bit & (cnt < DATA_CNT);
  assign wr_par       = acc_q ^ PAR_ODD;

  parity_accum u_parity_accum (
    .clk (CLK),
    .clr (acc_clr),
    .en  (acc_en),
    .d   (bus.SER_DATA),
    .q   (acc_q)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      data_q  <= '0;
      syl_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (start_accept) begin
      state   <= SHIFT;
      cnt     <= '0;
      data_q  <= '0;
      syl_q   <= bus.SYL_SEL;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        SHIFT: begin
          if (data_bit) begin
            for (int i = 0; i < SYL_BITS; i++) begin
              if (cnt == CW'(i)) begin
                data_q[i] <= bus.SER_DATA;
              end
            end
            cnt <= cnt + CW'(1);
            if (last_bit) begin
              state   <= WAIT_WR;
              valid_q <= 1'b1;
            end
          end
        end
        WAIT_WR: begin
          if (handshake) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            if (sample) begin
              ovr_q <= 1'b1;
            end
          end else if (bus.START | sample) begin
            ovr_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ASSEMBLER_PARITY_CHECK_EN
  logic perr_q;

  // The accumulator holds only data bits when the parity bit arrives
  always_ff @(posedge CLK) begin
    if (RESET) begin
      perr_q <= 1'b0;
    end else if (start_accept | handshake) begin
      perr_q <= 1'b0;
    end else if (last_bit) begin
      perr_q <= bus.SER_DATA ^ wr_par;
    end
  end

  assign bus.PAR_ERR = perr_q;
`else
  assign bus.PAR_ERR = 1'b0;
`endif

  assign bus.WR_VALID = valid_q;
  assign bus.WR_DATA  = data_q;
  assign bus.WR_PAR   = wr_par;
  assign bus.WR_SYL   = syl_q;
  assign bus.BUSY     = busy_q;
  assign bus.OVERRUN  = ovr_q;

endmodule

// File: tb/tb_serial_syllable_assembler.sv
// tb/tb_serial_syllable_assembler.sv - directed scoreboard bench for serial_syllable_assembler
module tb_serial_syllable_assembler;

  localparam int SB = 13;

  typedef struct packed {
    logic [SB-1:0] data;
    logic          par;
    logic          syl;
    logic          perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  serial_syllable_assembler_if #(.SYL_BITS(SB)) bus ();

  serial_syllable_assembler #(
    .SYL_BITS (SB),
    .PAR_ODD  (1'b1)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic odd_par(input logic [SB-1:0] w);
    return (($countones(w) % 2) == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".wr_valid"}, 32'(bus.WR_VALID), 32'd0);
    chk({tag, ".wr_data"},  32'(bus.WR_DATA),  32'd0);
    chk({tag, ".wr_par"},   32'(bus.WR_PAR),   32'd1);
    chk({tag, ".wr_syl"},   32'(bus.WR_SYL),   32'd0);
    chk({tag, ".busy"},     32'(bus.BUSY),     32'd0);
    chk({tag, ".par_err"},  32'(bus.PAR_ERR),  32'd0);
    chk({tag, ".overrun"},  32'(bus.OVERRUN),  32'd0);
  endtask

  task automatic do_start(input logic sel, input logic with_strobe);
    bus.START    = 1'b1;
    bus.SYL_SEL  = sel;
    bus.BIT_STB  = with_strobe;
    bus.SHIFT_EN = with_strobe;
    bus.SER_DATA = with_strobe;
    tick();
    bus.START    = 1'b0;
    bus.BIT_STB  = 1'b0;
    bus.SHIFT_EN = 1'b0;
    bus.SER_DATA = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.BIT_STB  = 1'b1;
    bus.SHIFT_EN = 1'b1;
    bus.SER_DATA = b;
    tick();
    bus.BIT_STB  = 1'b0;
    bus.SHIFT_EN = 1'b0;
  endtask

  task automatic gap_strobe(input logic b);
    bus.BIT_STB  = 1'b1;
    bus.SHIFT_EN = 1'b0;
    bus.SER_DATA = b;
    tick();
    bus.BIT_STB  = 1'b0;
  endtask

  task automatic send_data(input logic [SB-1:0] w);
    for (int i = 0; i < SB; i++) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [SB-1:0] w);
    send_data(w);
`ifdef SERIAL_ASSEMBLER_PARITY_CHECK_EN
    send_bit(odd_par(w));
`endif
  endtask

  task automatic push(input logic [SB-1:0] w, input logic syl, input logic perr);
    exp_t e;
    e.data = w;
    e.par  = odd_par(w);
    e.syl  = syl;
    e.perr = perr;
    sb_q.push_back(e);
  endtask

  task automatic expect_word(input string tag);
    exp_t e;
    int   n = 0;
    while (bus.WR_VALID !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, ".wr_valid"}, 32'(bus.WR_VALID), 32'd1);
    n_checks++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, ".wr_data"}, 32'(bus.WR_DATA), 32'(e.data));
      chk({tag, ".wr_par"},  32'(bus.WR_PAR),  32'(e.par));
      chk({tag, ".wr_syl"},  32'(bus.WR_SYL),  32'(e.syl));
      chk({tag, ".par_err"}, 32'(bus.PAR_ERR), 32'(e.perr));
    end
  endtask

  task automatic accept(input string tag);
    bus.WR_READY = 1'b1;
    tick();
    bus.WR_READY = 1'b0;
    chk({tag, ".valid_drop"}, 32'(bus.WR_VALID), 32'd0);
    chk({tag, ".busy_drop"},  32'(bus.BUSY),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.START    = 1'b0;
    bus.SYL_SEL  = 1'b0;
    bus.BIT_STB  = 1'b0;
    bus.SHIFT_EN = 1'b0;
    bus.SER_DATA = 1'b0;
    bus.WR_READY = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    // Contiguous syllable 0x1A5B with SYL_SEL = 1
    do_start(1'b1, 1'b0);
    chk("t1.busy_rise", 32'(bus.BUSY), 32'd1);
    push(13'h1A5B, 1'b1, 1'b0);
    send_frame(13'h1A5B);
    expect_word("t1");
    accept("t1");

    // Same word with gap strobes; a strobe alongside START in IDLE is ignored
    do_start(1'b0, 1'b1);
    push(13'h1A5B, 1'b0, 1'b0);
    for (int i = 0; i < SB; i++) begin
      gap_strobe(~bus.WR_DATA[0]);
      tick();
      send_bit(13'h1A5B >> i);
    end
`ifdef SERIAL_ASSEMBLER_PARITY_CHECK_EN
    gap_strobe(1'b0);
    send_bit(odd_par(13'h1A5B));
`endif
    expect_word("t2");
    accept("t2");

    // Abort after 6 bits, restart with new SYL_SEL
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    chk("t3.busy_mid", 32'(bus.BUSY), 32'd1);
    chk("t3.valid_mid", 32'(bus.WR_VALID), 32'd0);
    do_start(1'b1, 1'b0);
    push(13'h0A3C, 1'b1, 1'b0);
    send_frame(13'h0A3C);
    expect_word("t3");
    accept("t3");

    // Stall in WAIT_WR, extra bits and START set OVERRUN, then back-to-back restart
    do_start(1'b0, 1'b0);
    push(13'h1234, 1'b0, 1'b0);
    send_frame(13'h1234);
    expect_word("t4");
    send_bit(1'b1);
    send_bit(1'b0);
    do_start(1'b1, 1'b0);
    chk("t4.data_hold", 32'(bus.WR_DATA),  32'h1234);
    chk("t4.overrun",   32'(bus.OVERRUN),  32'd1);
    chk("t4.valid_hold", 32'(bus.WR_VALID), 32'd1);
    chk("t4.syl_hold",  32'(bus.WR_SYL),   32'd0);
    bus.START    = 1'b1;
    bus.SYL_SEL  = 1'b1;
    bus.WR_READY = 1'b1;
    tick();
    bus.START    = 1'b0;
    bus.WR_READY = 1'b0;
    chk("t4.b2b_valid",   32'(bus.WR_VALID), 32'd0);
    chk("t4.b2b_busy",    32'(bus.BUSY),     32'd1);
    chk("t4.b2b_overrun", 32'(bus.OVERRUN),  32'd0);
    chk("t4.b2b_syl",     32'(bus.WR_SYL),   32'd1);
    push(13'h0F0F, 1'b1, 1'b0);
    send_frame(13'h0F0F);
    expect_word("t4b");
    accept("t4b");

    // RESET while waiting for the write buffer, with WR_READY high
    do_start(1'b1, 1'b0);
    push(13'h1FFF, 1'b1, 1'b0);
    send_frame(13'h1FFF);
    expect_word("t5");
    rst          = 1'b1;
    bus.WR_READY = 1'b1;
    tick();
    rst          = 1'b0;
    bus.WR_READY = 1'b0;
    chk_reset("t5.rst_wait");

    // RESET in the middle of a shift
    do_start(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("t6.rst_shift");

`ifdef SERIAL_ASSEMBLER_PARITY_CHECK_EN
    // Received parity wrong (1 where 0 is generated), then correct
    do_start(1'b0, 1'b0);
    push(13'h0001, 1'b0, 1'b1);
    send_data(13'h0001);
    send_bit(1'b1);
    expect_word("t7.bad");
    accept("t7.bad");
    chk("t7.perr_clear", 32'(bus.PAR_ERR), 32'd0);
    do_start(1'b0, 1'b0);
    push(13'h0001, 1'b0, 1'b0);
    send_data(13'h0001);
    send_bit(1'b0);
    expect_word("t7.good");
    accept("t7.good");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
